requant_lane_scheduler: RTL and testbench
=========================================

# requant_lane_scheduler

Time-shares one 3-stage requantization unit (bias add, fixed-point multiply, shift, zero-point add, int8 clamp) among the 8 parallel accumulator lanes of the int8 engine. The block accepts one 8-lane accumulator vector and issues the lanes serially into the unit, fetching each lane's per-channel bias from a synchronous bias ROM. It reassembles the 8 clamped bytes into one output word and presents that word on a ready/valid stream. It sits between the lane accumulator array and the activation write-back path.

## Interface
- LANES, 8, accumulator lanes per vector
- ACC_WIDTH, 32, accumulator width (signed)
- BIAS_WIDTH, 32, bias width (signed)
- DATA_WIDTH, 8, quantized output width (signed)
- CH_WIDTH, 10, channel index / bias ROM address width
- QU_LATENCY, 3, requantization unit latency, i_valid to o_valid

Ports:
- Reset is rst_n, asynchronous, active-low; the clock is clk.
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- s_valid  in  1  accumulator vector valid
- s_ready  out  1  input buffer empty
- s_acc  in  LANES*ACC_WIDTH  packed accumulators; lane 0 is the LSBs
- s_ch_base  in  CH_WIDTH  channel of lane 0; lane k uses s_ch_base+k
- bias_addr  out  CH_WIDTH  bias ROM address, registered
- bias_data  in  BIAS_WIDTH  ROM data, valid one cycle after bias_addr
- q_valid  out  1  to unit i_valid, registered
- q_acc  out  ACC_WIDTH  to unit accumulator_in, registered
- q_bias  out  BIAS_WIDTH  to unit bias_in; direct pass-through of bias_data
- q_o_valid  in  1  from unit o_valid
- q_data  in  DATA_WIDTH  from unit clamped_output
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  LANES*DATA_WIDTH  packed bytes; lane 0 is the LSBs
- m_ch_base  out  CH_WIDTH  s_ch_base of the vector in m_data
- err_spurious  out  1  sticky; set when q_o_valid arrives with nothing outstanding

## Operation
- Input buffer: captures s_acc and s_ch_base on s_valid&&s_ready and sets in_full. s_ready = !in_full.
- FSM states and transitions:
  - IDLE → ISSUE when in_full && !out_pending && outstanding==0.
  - ISSUE: one lane per cycle. Each cycle drives bias_addr <= base+lane_cnt (mod 2^CH_WIDTH) and increments lane_cnt 0..LANES-1. The issued lane index is delayed one cycle; in that cycle the block drives q_valid=1 and q_acc=acc[lane].
  - ISSUE → WAIT after lane LANES-1 is addressed. in_full clears in the same cycle, so the next vector can be accepted.
  - WAIT → IDLE when the last lane is collected.
- Collection: every q_o_valid writes q_data into out_buf[col_cnt] and increments col_cnt. When lane LANES-1 is written, col_cnt returns to 0 and out_pending is set.
- Output: m_valid = out_pending. m_data and m_ch_base stay stable while m_valid&&!m_ready. out_pending clears on m_valid&&m_ready.
- Outstanding counter (0..LANES): increments on q_valid, decrements on q_o_valid, and holds when both occur in the same cycle. q_o_valid with outstanding==0 sets err_spurious and the sample is dropped.
- The unit cannot stall. Issue therefore begins only with out_buf free, which guarantees a slot for every result.
- Reset mid-operation clears all state. The unit shares rst_n, so in-flight results vanish with it.
- Reset values: s_ready=1, bias_addr=0, q_valid=0, q_acc=0, m_valid=0, m_data=0, m_ch_base=0, err_spurious=0. State is IDLE with all counters at 0.

## Timing
- Input handshake at edge E0.
- E1: bias_addr=base+0.
- E2: q_valid/q_acc for lane 0, with q_bias valid in the same cycle.
- Lane k is issued at E(2+k). q_o_valid for lane k is high after E(5+k).
- Lane 7 is collected at E13, so m_valid rises after E13. Latency = 2+QU_LATENCY+LANES = 13 cycles.
- q_valid is high for exactly LANES consecutive cycles per vector, with no gaps.
- s_ready returns high after E9. A second vector may be accepted while the first is still in flight.
- The second vector's issue starts the cycle after out_pending clears and outstanding==0. With m_ready=1 the period is 14 cycles per vector.
- Simultaneous accept and drain in the same cycle is legal.
- If m_ready is held low, the second vector waits in the input buffer and s_ready stays 0.

## Structure
- Shared package holds:
  - LANES, ACC_WIDTH, BIAS_WIDTH, DATA_WIDTH, CH_WIDTH, QU_LATENCY
  - the FSM state enum (IDLE, ISSUE, WAIT)
  - the lane-slice helper constants
- One sub-module, requant_out_collector, holds the col_cnt, out_buf, out_pending and m_* handshake logic.
- The requantization unit is instantiated by the parent, not inside this block.

## Test plan
- Single vector, acc lanes = 1000·(k+1), s_ch_base=4 → bias_addr sequence 4..11 on E1..E8; q_valid high E2..E9; m_valid after E13 with bytes matching the golden requant model.
- Back-to-back vectors with m_ready=1 → second s_ready after E9; second m_valid exactly 14 cycles after the first; no lost or reordered bytes.
- m_ready held low for 20 cycles → m_data stable; second vector is accepted and then s_ready stays 0; no q_valid is issued until the drain.
- s_ch_base=1020, CH_WIDTH=10 → bias_addr wraps 1020..1023, 0..3.
- rst_n asserted during the ISSUE of lane 4 → all outputs reach reset values asynchronously; a clean vector after release produces the correct word.
- Forced q_o_valid pulse while idle → err_spurious=1 and sticky until reset; m_valid stays 0.

Source files
------------

// File: rtl/requant_lane_scheduler_pkg.sv
// Shared parameters, FSM encoding and lane-slice constants for the requant lane scheduler.
package requant_lane_scheduler_pkg;
  localparam int LANES      = 8;
  localparam int ACC_WIDTH  = 32;
  localparam int BIAS_WIDTH = 32;
  localparam int DATA_WIDTH = 8;
  localparam int CH_WIDTH   = 10;
  localparam int QU_LATENCY = 3;

  localparam int LANE_W    = $clog2(LANES);
  localparam int OUTST_W   = $clog2(LANES + 1);
  localparam int ACC_VEC_W = LANES * ACC_WIDTH;
  localparam int OUT_VEC_W = LANES * DATA_WIDTH;

  typedef logic [LANE_W-1:0] lane_t;
  localparam lane_t LAST_LANE = lane_t'(LANES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/requant_out_collector.sv
// Reassembles serial requant results into one word and holds it on a ready/valid output.
module requant_out_collector
  import requant_lane_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  col_en,
  input  logic [DATA_WIDTH-1:0] col_data,
  input  logic [CH_WIDTH-1:0]   ch_base,
  output logic                  col_last,
  output logic                  out_pending,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_VEC_W-1:0]  m_data,
  output logic [CH_WIDTH-1:0]   m_ch_base
);
  lane_t col_cnt;

  assign col_last = col_en && (col_cnt == LAST_LANE);
  assign m_valid  = out_pending;

  // m_data doubles as the lane buffer; issue never starts while a word is pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt     <= '0;
      out_pending <= 1'b0;
      m_data      <= '0;
      m_ch_base   <= '0;
    end else begin
      if (col_en) begin
        m_data[col_cnt*DATA_WIDTH +: DATA_WIDTH] <= col_data;
        col_cnt <= col_last ? '0 : col_cnt + lane_t'(1);
      end
      if (col_last) begin
        out_pending <= 1'b1;
        m_ch_base   <= ch_base;
      end else if (m_valid && m_ready) begin
        out_pending <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/requant_lane_scheduler.sv
// Serialises an 8-lane accumulator vector through one shared requant unit and
// gathers the clamped bytes back into a word (13-cycle latency, no unit stall).
module requant_lane_scheduler
  import requant_lane_scheduler_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ACC_VEC_W-1:0]  s_acc,
  input  logic [CH_WIDTH-1:0]   s_ch_base,
  output logic [CH_WIDTH-1:0]   bias_addr,
  input  logic [BIAS_WIDTH-1:0] bias_data,
  output logic                  q_valid,
  output logic [ACC_WIDTH-1:0]  q_acc,
  output logic [BIAS_WIDTH-1:0] q_bias,
  input  logic                  q_o_valid,
  input  logic [DATA_WIDTH-1:0] q_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_VEC_W-1:0]  m_data,
  output logic [CH_WIDTH-1:0]   m_ch_base,
  output logic                  err_spurious
);
  state_t               state, state_nxt;
  logic                 in_full;
  logic [ACC_VEC_W-1:0] in_acc;
  logic [CH_WIDTH-1:0]  in_ch_base, issue_ch_base;
  lane_t                lane_cnt, addr_lane;
  logic [OUTST_W-1:0]   outstanding;
  logic                 out_pending, col_en, col_last, start;
  logic                 addr_load, lane_issue, issue_last;

  assign s_ready    = !in_full;
  assign q_bias     = bias_data;
  assign start      = in_full && !out_pending && (outstanding == '0);
  assign issue_last = (state == ISSUE) && (lane_cnt == LAST_LANE);
  assign col_en     = q_o_valid && (outstanding != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (lane_cnt == LAST_LANE) state_nxt = WAIT;
      WAIT:    if (col_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // lane_cnt names the lane currently on bias_addr; it is issued to the unit one cycle later.
  always_comb begin
    addr_load  = 1'b0;
    addr_lane  = '0;
    lane_issue = 1'b0;
    case (state)
      IDLE:  addr_load = start;
      ISSUE: begin
        lane_issue = 1'b1;
        addr_load  = (lane_cnt != LAST_LANE);
        addr_lane  = lane_cnt + lane_t'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_full       <= 1'b0;
      in_acc        <= '0;
      in_ch_base    <= '0;
      issue_ch_base <= '0;
      lane_cnt      <= '0;
      bias_addr     <= '0;
      q_valid       <= 1'b0;
      q_acc         <= '0;
    end else begin
      if (s_valid && s_ready) begin
        in_full    <= 1'b1;
        in_acc     <= s_acc;
        in_ch_base <= s_ch_base;
      end else if (issue_last) begin
        in_full <= 1'b0;
      end
      if (start && state == IDLE) issue_ch_base <= in_ch_base;
      if (addr_load) begin
        bias_addr <= in_ch_base + CH_WIDTH'(addr_lane);
        lane_cnt  <= addr_lane;
      end else if (issue_last) begin
        lane_cnt <= '0;
      end
      q_valid <= lane_issue;
      if (lane_issue) q_acc <= in_acc[lane_cnt*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // A result with nothing outstanding is dropped so it cannot corrupt the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding  <= '0;
      err_spurious <= 1'b0;
    end else begin
      case ({q_valid, col_en})
        2'b10:   outstanding <= outstanding + OUTST_W'(1);
        2'b01:   outstanding <= outstanding - OUTST_W'(1);
        default: ;
      endcase
      if (q_o_valid && outstanding == '0) err_spurious <= 1'b1;
    end
  end

  requant_out_collector u_collector (
    .clk         (clk),
    .rst_n       (rst_n),
    .col_en      (col_en),
    .col_data    (q_data),
    .ch_base     (issue_ch_base),
    .col_last    (col_last),
    .out_pending (out_pending),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_ch_base   (m_ch_base)
  );
endmodule

// File: tb/tb_requant_lane_scheduler.sv
// Bench for requant_lane_scheduler with a behavioural bias ROM and requant unit around it.
module tb_requant_lane_scheduler;
  import requant_lane_scheduler_pkg::*;

  localparam int MULT = 77;
  localparam int SHIFT = 10;
  localparam int ZP = 3;
  localparam int LAT = 2 + QU_LATENCY + LANES;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                  s_valid = 1'b0, s_ready, q_valid, q_o_valid, m_valid, err_spurious;
  logic                  m_ready = 1'b0, inj_vld = 1'b0;
  logic [ACC_VEC_W-1:0]  s_acc = '0;
  logic [CH_WIDTH-1:0]   s_ch_base = '0, bias_addr, m_ch_base;
  logic [BIAS_WIDTH-1:0] bias_data, q_bias;
  logic [ACC_WIDTH-1:0]  q_acc;
  logic [DATA_WIDTH-1:0] q_data;
  logic [OUT_VEC_W-1:0]  m_data;

  requant_lane_scheduler dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_acc(s_acc),
    .s_ch_base(s_ch_base), .bias_addr(bias_addr), .bias_data(bias_data), .q_valid(q_valid),
    .q_acc(q_acc), .q_bias(q_bias), .q_o_valid(q_o_valid), .q_data(q_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch_base(m_ch_base),
    .err_spurious(err_spurious)
  );

  function automatic logic [BIAS_WIDTH-1:0] bias_of(input logic [CH_WIDTH-1:0] a);
    return BIAS_WIDTH'(int'(a) * 13 - 6000);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rq(input longint acc, input longint bias);
    longint s;
    s = ((acc + bias) * MULT) >>> SHIFT;
    s = s + ZP;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return DATA_WIDTH'(s);
  endfunction

  // Reference: every lane k uses channel base+k modulo the ROM size.
  function automatic logic [OUT_VEC_W-1:0] model_word(input logic [ACC_VEC_W-1:0] acc,
                                                      input logic [CH_WIDTH-1:0] base);
    logic [OUT_VEC_W-1:0] w;
    logic [CH_WIDTH-1:0] ch;
    logic signed [ACC_WIDTH-1:0] a;
    w = '0;
    for (int k = 0; k < LANES; k++) begin
      ch = base + CH_WIDTH'(k);
      a = acc[k*ACC_WIDTH +: ACC_WIDTH];
      w[k*DATA_WIDTH +: DATA_WIDTH] = rq(a, $signed(bias_of(ch)));
    end
    return w;
  endfunction

  function automatic logic [ACC_VEC_W-1:0] rand_vec();
    logic [ACC_VEC_W-1:0] v;
    for (int k = 0; k < LANES; k++)
      v[k*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(int'($urandom_range(0, 40000)) - 20000);
    return v;
  endfunction

  // Synchronous bias ROM and a non-stalling requant unit sharing rst_n.
  always @(posedge clk) bias_data <= bias_of(bias_addr);

  logic [QU_LATENCY-1:0] u_vld;
  logic [DATA_WIDTH-1:0] u_dat [QU_LATENCY];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) u_vld <= '0;
    else begin
      u_vld <= {u_vld[QU_LATENCY-2:0], q_valid};
      u_dat[0] <= rq($signed(q_acc), $signed(q_bias));
      for (int i = 1; i < QU_LATENCY; i++) u_dat[i] <= u_dat[i-1];
    end
  end
  assign q_o_valid = u_vld[QU_LATENCY-1] | inj_vld;
  assign q_data = inj_vld ? 8'h5a : u_dat[QU_LATENCY-1];

  int cyc = 0;
  int qv_total = 0;
  logic [OUT_VEC_W-1:0] got_dat[$];
  logic [CH_WIDTH-1:0]  got_base[$];
  int                   got_cyc[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && q_valid) qv_total <= qv_total + 1;
    if (rst_n && m_valid && m_ready) begin
      got_dat.push_back(m_data);
      got_base.push_back(m_ch_base);
      got_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;
  int rd_ptr = 0;
  localparam logic [119:0] RST_EXP = {1'b1, 119'b0};

  // Called at a negedge with s_ready high; returns at the negedge after the accept edge.
  task automatic send(input logic [ACC_VEC_W-1:0] acc, input logic [CH_WIDTH-1:0] base,
                      output int e0);
    s_valid = 1'b1; s_acc = acc; s_ch_base = base;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    e0 = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_ready, bias_addr, q_valid, q_acc, m_valid, m_data, m_ch_base, err_spurious} !== RST_EXP) begin
      errors++; $display("FAIL reset_values got %h exp %h",
        {s_ready, bias_addr, q_valid, q_acc, m_valid, m_data, m_ch_base, err_spurious}, RST_EXP);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || q_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release s_ready=%b q_valid=%b exp 1/0", s_ready, q_valid);
    end
  endtask

  task automatic test_single();
    logic [ACC_VEC_W-1:0] acc;
    logic [CH_WIDTH-1:0] exp_a;
    logic exp_qv;
    int e0;
    for (int k = 0; k < LANES; k++) acc[k*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(1000 * (k + 1));
    m_ready = 1'b0;
    send(acc, 10'd4, e0);
    for (int e = 1; e <= 15; e++) begin
      @(negedge clk);
      if (e <= 8) begin
        exp_a = CH_WIDTH'(4 + e - 1);
        checks++;
        if (bias_addr !== exp_a) begin
          errors++; $display("FAIL single_bias_addr E%0d got %0d exp %0d", e, bias_addr, exp_a);
        end
      end
      exp_qv = (e >= 2 && e <= 9);
      checks++;
      if (q_valid !== exp_qv) begin
        errors++; $display("FAIL single_q_valid E%0d got %b exp %b", e, q_valid, exp_qv);
      end
      if (exp_qv) begin
        checks++;
        if (q_acc !== acc[(e-2)*ACC_WIDTH +: ACC_WIDTH]) begin
          errors++; $display("FAIL single_q_acc E%0d got %0d exp %0d", e, q_acc, acc[(e-2)*ACC_WIDTH +: ACC_WIDTH]);
        end
      end
      checks++;
      if (m_valid !== (e >= LAT) || s_ready !== (e >= 9)) begin
        errors++; $display("FAIL single_flags E%0d m_valid=%b s_ready=%b exp %b/%b", e, m_valid, s_ready, e >= LAT, e >= 9);
      end
    end
    checks++;
    if (m_data !== model_word(acc, 10'd4) || m_ch_base !== 10'd4) begin
      errors++; $display("FAIL single_word got %h/%0d exp %h/4", m_data, m_ch_base, model_word(acc, 10'd4));
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain m_valid got %b exp 0", m_valid);
    end
    rd_ptr = got_dat.size();
  endtask

  task automatic test_wrap();
    logic [ACC_VEC_W-1:0] acc;
    logic [CH_WIDTH-1:0] exp_a;
    int e0, g;
    acc = rand_vec();
    m_ready = 1'b1;
    send(acc, 10'd1020, e0);
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_a = CH_WIDTH'((1020 + e - 1) % 1024);
      checks++;
      if (bias_addr !== exp_a) begin
        errors++; $display("FAIL wrap_bias_addr E%0d got %0d exp %0d", e, bias_addr, exp_a);
      end
    end
    g = 0;
    while (got_dat.size() <= rd_ptr && g < 40) begin @(negedge clk); g++; end
    checks++;
    if (got_dat.size() <= rd_ptr) begin
      errors++; $display("FAIL wrap_timeout got %0d words exp %0d", got_dat.size(), rd_ptr + 1);
    end else begin
      if (got_dat[rd_ptr] !== model_word(acc, 10'd1020) || got_base[rd_ptr] !== 10'd1020 ||
          got_cyc[rd_ptr] - e0 !== LAT) begin
        errors++; $display("FAIL wrap_word got %h/%0d lat %0d exp %h/1020 lat %0d", got_dat[rd_ptr],
          got_base[rd_ptr], got_cyc[rd_ptr] - e0, model_word(acc, 10'd1020), LAT);
      end
      rd_ptr++;
    end
  endtask

  task automatic test_back_to_back();
    logic [ACC_VEC_W-1:0] v1, v2;
    logic [CH_WIDTH-1:0] b1, b2;
    int e0, e0b, g, qv0;
    v1 = rand_vec(); v2 = rand_vec();
    b1 = CH_WIDTH'($urandom_range(0, 1023)); b2 = CH_WIDTH'($urandom_range(0, 1023));
    m_ready = 1'b1;
    qv0 = qv_total;
    send(v1, b1, e0);
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== (e >= 9)) begin
        errors++; $display("FAIL b2b_s_ready E%0d got %b exp %b", e, s_ready, e >= 9);
      end
    end
    send(v2, b2, e0b);
    g = 0;
    while (got_dat.size() < rd_ptr + 2 && g < 60) begin @(negedge clk); g++; end
    checks++;
    if (got_dat.size() < rd_ptr + 2) begin
      errors++; $display("FAIL b2b_timeout got %0d words exp %0d", got_dat.size() - rd_ptr, 2);
    end else begin
      if (got_dat[rd_ptr] !== model_word(v1, b1) || got_base[rd_ptr] !== b1) begin
        errors++; $display("FAIL b2b_word0 got %h/%0d exp %h/%0d", got_dat[rd_ptr], got_base[rd_ptr], model_word(v1, b1), b1);
      end
      checks++;
      if (got_dat[rd_ptr+1] !== model_word(v2, b2) || got_base[rd_ptr+1] !== b2) begin
        errors++; $display("FAIL b2b_word1 got %h/%0d exp %h/%0d", got_dat[rd_ptr+1], got_base[rd_ptr+1], model_word(v2, b2), b2);
      end
      checks++;
      if (got_cyc[rd_ptr] - e0 !== LAT || got_cyc[rd_ptr+1] - got_cyc[rd_ptr] !== LAT + 1) begin
        errors++; $display("FAIL b2b_timing got lat %0d period %0d exp %0d %0d",
          got_cyc[rd_ptr] - e0, got_cyc[rd_ptr+1] - got_cyc[rd_ptr], LAT, LAT + 1);
      end
      rd_ptr += 2;
    end
    checks++;
    if (qv_total - qv0 !== 2 * LANES) begin
      errors++; $display("FAIL b2b_q_valid_count got %0d exp %0d", qv_total - qv0, 2 * LANES);
    end
  endtask

  task automatic test_stall();
    logic [ACC_VEC_W-1:0] v1, v2;
    logic [OUT_VEC_W-1:0] held;
    int e0, g;
    v1 = rand_vec(); v2 = rand_vec();
    m_ready = 1'b0;
    send(v1, 10'd100, e0);
    g = 0;
    while (!s_ready && g < 20) begin @(negedge clk); g++; end
    send(v2, 10'd200, e0);
    g = 0;
    while (!m_valid && g < 20) begin @(negedge clk); g++; end
    held = m_data;
    checks++;
    if (held !== model_word(v1, 10'd100)) begin
      errors++; $display("FAIL stall_word0 got %h exp %h", held, model_word(v1, 10'd100));
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (m_data !== held || m_valid !== 1'b1 || s_ready !== 1'b0 || q_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold c%0d data %h v=%b sr=%b qv=%b exp %h 1 0 0", c, m_data, m_valid, s_ready, q_valid, held);
      end
    end
    m_ready = 1'b1;
    g = 0;
    while (got_dat.size() < rd_ptr + 2 && g < 60) begin @(negedge clk); g++; end
    checks++;
    if (got_dat.size() < rd_ptr + 2) begin
      errors++; $display("FAIL stall_timeout got %0d words exp 2", got_dat.size() - rd_ptr);
    end else begin
      if (got_dat[rd_ptr+1] !== model_word(v2, 10'd200) || got_base[rd_ptr+1] !== 10'd200) begin
        errors++; $display("FAIL stall_word1 got %h/%0d exp %h/200", got_dat[rd_ptr+1], got_base[rd_ptr+1], model_word(v2, 10'd200));
      end
      rd_ptr += 2;
    end
  endtask

  task automatic test_random();
    logic [ACC_VEC_W-1:0] va [8];
    logic [CH_WIDTH-1:0]  vb [8];
    int g;
    for (int i = 0; i < 8; i++) begin
      va[i] = rand_vec();
      vb[i] = CH_WIDTH'($urandom_range(0, 1023));
    end
    fork
      begin
        int gs, dummy;
        for (int i = 0; i < 8; i++) begin
          gs = 0;
          while (!s_ready && gs < 200) begin @(negedge clk); gs++; end
          send(va[i], vb[i], dummy);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int c = 0; c < 300; c++) begin
          m_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        m_ready = 1'b1;
      end
    join
    g = 0;
    while (got_dat.size() < rd_ptr + 8 && g < 200) begin @(negedge clk); g++; end
    checks++;
    if (got_dat.size() !== rd_ptr + 8) begin
      errors++; $display("FAIL random_count got %0d words exp 8", got_dat.size() - rd_ptr);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_dat[rd_ptr+i] !== model_word(va[i], vb[i]) || got_base[rd_ptr+i] !== vb[i]) begin
          errors++; $display("FAIL random_word%0d got %h/%0d exp %h/%0d", i, got_dat[rd_ptr+i],
            got_base[rd_ptr+i], model_word(va[i], vb[i]), vb[i]);
        end
      end
      rd_ptr += 8;
    end
  endtask

  task automatic test_reset_mid();
    logic [ACC_VEC_W-1:0] acc;
    logic [CH_WIDTH-1:0] base;
    int e0, g;
    acc = rand_vec();
    base = CH_WIDTH'($urandom_range(0, 1023));
    m_ready = 1'b1;
    send(rand_vec(), 10'd50, e0);
    repeat (5) @(negedge clk);
    checks++;
    if (bias_addr !== CH_WIDTH'(54)) begin
      errors++; $display("FAIL mid_lane4_addr got %0d exp 54", bias_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, bias_addr, q_valid, q_acc, m_valid, m_data, m_ch_base, err_spurious} !== RST_EXP) begin
      errors++; $display("FAIL mid_async_reset got %h exp %h",
        {s_ready, bias_addr, q_valid, q_acc, m_valid, m_data, m_ch_base, err_spurious}, RST_EXP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(acc, base, e0);
    g = 0;
    while (got_dat.size() <= rd_ptr && g < 40) begin @(negedge clk); g++; end
    checks++;
    if (got_dat.size() !== rd_ptr + 1) begin
      errors++; $display("FAIL mid_count got %0d words exp 1", got_dat.size() - rd_ptr);
    end else begin
      if (got_dat[rd_ptr] !== model_word(acc, base) || got_base[rd_ptr] !== base || err_spurious !== 1'b0) begin
        errors++; $display("FAIL mid_clean_word got %h/%0d err %b exp %h/%0d 0", got_dat[rd_ptr],
          got_base[rd_ptr], err_spurious, model_word(acc, base), base);
      end
      rd_ptr++;
    end
  endtask

  task automatic test_spurious();
    repeat (3) @(negedge clk);
    inj_vld = 1'b1;
    @(negedge clk);
    inj_vld = 1'b0;
    checks++;
    if (err_spurious !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL spurious_set err=%b m_valid=%b exp 1/0", err_spurious, m_valid);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (err_spurious !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL spurious_sticky err=%b m_valid=%b exp 1/0", err_spurious, m_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (err_spurious !== 1'b0) begin
      errors++; $display("FAIL spurious_clear got %b exp 0", err_spurious);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
